// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: FSM encoding, LFSR/MISR taps, default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bist_pkg;

  // Default geometry of the circuit under test and the run length counter
  localparam int DEF_PI_WIDTH     = 35;
  localparam int DEF_PO_WIDTH     = 23;
  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_FLUSH_CYCLES = 4;

  // Pattern generator feedback taps, x^35 + x^33 + 1
  localparam int LFSR_TAP_A = 34;
  localparam int LFSR_TAP_B = 32;

  // Response compactor feedback taps, x^23 + x^18 + 1
  localparam int MISR_TAP_A = 22;
  localparam int MISR_TAP_B = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bist_sequencer_if.sv
// Control, pattern and response bundle between a BIST controller and the sequencer.
// Latency: n/a (wires only); po is expected back in the same cycle as pi.
// Backpressure: none, the sequencer free-runs once a run is accepted.
interface bist_sequencer_if
  import bist_pkg::*;
#(
  parameter int PI_WIDTH  = DEF_PI_WIDTH,
  parameter int PO_WIDTH  = DEF_PO_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 start;
  logic [CNT_WIDTH-1:0] num_patterns;
  logic [PI_WIDTH-1:0]  seed;
  logic [PO_WIDTH-1:0]  golden;
  logic [PO_WIDTH-1:0]  po;
  logic [PI_WIDTH-1:0]  pi;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [PO_WIDTH-1:0]  signature;

  // Controller / CUT side: issues the run and returns the CUT response
  modport master (
    output start, num_patterns, seed, golden, po,
    input  pi, busy, done, pass, signature
  );

  // Sequencer side
  modport slave (
    input  start, num_patterns, seed, golden, po,
    output pi, busy, done, pass, signature
  );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting the CUT response each enabled cycle.
// Latency: 1 cycle from din to sig; sig_next exposes the value about to be loaded.
// Backpressure: none; en simply freezes the signature.
module bist_misr
  import bist_pkg::*;
#(
  parameter int WIDTH = DEF_PO_WIDTH,
  parameter int TAP_A = MISR_TAP_A,
  parameter int TAP_B = MISR_TAP_B
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  logic [WIDTH-1:0] sig_q;

  // Shift with feedback, then fold in the parallel response
  assign sig_next = {sig_q[WIDTH-2:0], sig_q[TAP_A] ^ sig_q[TAP_B]} ^ din;
  assign sig      = sig_q;

  // Clear wins over enable so a fresh run always starts from zero
  always_ff @(posedge ck) begin
    if (rst || clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// BIST run sequencer: LFSR patterns into the CUT, MISR compaction, golden compare.
// Latency: DONE pulses num_patterns + FLUSH_CYCLES + 2 cycles after START is accepted.
// Backpressure: none; START is only honoured in IDLE and ignored while a run is active.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int PI_WIDTH     = DEF_PI_WIDTH,
  parameter int PO_WIDTH     = DEF_PO_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input logic              ck,
  input logic              rst,
  bist_sequencer_if.slave  bus
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [PI_WIDTH-1:0]  gen_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [FCW-1:0]       fcnt_q;
  logic                 pass_q;
  logic [PO_WIDTH-1:0]  misr_sig;
  logic [PO_WIDTH-1:0]  misr_next;
  logic                 run_last;
  logic                 flush_last;
  logic                 in_load;
  logic                 in_run;
  logic                 in_flush;

  assign in_load  = (state_q == ST_LOAD);
  assign in_run   = (state_q == ST_RUN);
  assign in_flush = (state_q == ST_FLUSH);

  // Counter compares against count-1 so a full-scale count never needs a wider counter
  assign run_last   = (cnt_q == (num_q - CNT_WIDTH'(1)));
  assign flush_last = (fcnt_q == FCW'(FLUSH_CYCLES - 1));

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD:  state_d = (bus.num_patterns != '0) ? ST_RUN : ST_FLUSH;
      ST_RUN:   if (run_last) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pattern generator: seeded in LOAD (zero seed would lock up), steps only in RUN
  always_ff @(posedge ck) begin
    if (rst) begin
      gen_q <= '0;
    end else if (in_load) begin
      gen_q <= (bus.seed == '0) ? PI_WIDTH'(1) : bus.seed;
    end else if (in_run) begin
      gen_q <= {gen_q[PI_WIDTH-2:0], gen_q[LFSR_TAP_A] ^ gen_q[LFSR_TAP_B]};
    end
  end

  // Pattern counter and latched run length
  always_ff @(posedge ck) begin
    if (rst) begin
      cnt_q <= '0;
      num_q <= '0;
    end else if (in_load) begin
      cnt_q <= '0;
      num_q <= bus.num_patterns;
    end else if (in_run) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Flush counter, runs 0..FLUSH_CYCLES-1 while draining the compactor
  always_ff @(posedge ck) begin
    if (rst || in_load) begin
      fcnt_q <= '0;
    end else if (in_flush) begin
      fcnt_q <= flush_last ? '0 : fcnt_q + FCW'(1);
    end
  end

  // Verdict: compare the signature being loaded on the last flush edge
  always_ff @(posedge ck) begin
    if (rst || in_load) begin
      pass_q <= 1'b0;
    end else if (in_flush && flush_last) begin
      pass_q <= (misr_next == bus.golden);
    end
  end

  bist_misr #(
    .WIDTH (PO_WIDTH),
    .TAP_A (MISR_TAP_A),
    .TAP_B (MISR_TAP_B)
  ) u_misr (
    .ck       (ck),
    .rst      (rst),
    .clr      (in_load),
    .en       (in_run || in_flush),
    .din      (bus.po),
    .sig      (misr_sig),
    .sig_next (misr_next)
  );

  assign bus.pi        = in_run ? gen_q : '0;
  assign bus.busy      = in_load || in_run || in_flush;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = misr_sig;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: model-predicted per-cycle PI/BUSY/DONE/SIGNATURE/PASS.
// Latency: expectations are queued at START and popped one per cycle from the accept edge.
// Backpressure: n/a.
module tb_bist_sequencer;
  import bist_pkg::*;

  localparam int PIW = 35;
  localparam int POW = 23;
  localparam int CW  = 16;
  localparam int FC  = 4;

  typedef struct {
    logic [PIW-1:0] pi;
    logic           busy;
    logic           done;
    logic [POW-1:0] sig;
    logic           sig_v;
    logic           pass;
    logic           pass_v;
    logic           detail;
  } exp_t;

  logic           ck = 1'b0;
  logic           rst;
  logic           po_mode;
  logic [POW-1:0] po_const;
  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];

  always #5 ck = ~ck;

  bist_sequencer_if #(.PI_WIDTH(PIW), .PO_WIDTH(POW), .CNT_WIDTH(CW)) bus ();

  bist_sequencer #(
    .PI_WIDTH     (PIW),
    .PO_WIDTH     (POW),
    .CNT_WIDTH    (CW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // CUT stand-in: constant response or a fold of the applied pattern
  function automatic logic [POW-1:0] po_fn(input logic [PIW-1:0] p, input logic mode,
                                           input logic [POW-1:0] c);
    return mode ? (p[POW-1:0] ^ {11'b0, p[PIW-1:POW]}) : c;
  endfunction

  assign bus.po = po_fn(bus.pi, po_mode, po_const);

  function automatic logic [PIW-1:0] lfsr_step(input logic [PIW-1:0] g);
    return {g[33:0], g[34] ^ g[32]};
  endfunction

  function automatic logic [POW-1:0] misr_step(input logic [POW-1:0] m, input logic [POW-1:0] d);
    return {m[21:0], m[22] ^ m[17]} ^ d;
  endfunction

  function automatic exp_t mk(input logic [PIW-1:0] pi, input logic busy, input logic done,
                              input logic [POW-1:0] sig, input logic sig_v,
                              input logic pass, input logic pass_v, input logic detail);
    exp_t e;
    e.pi = pi; e.busy = busy; e.done = done; e.sig = sig; e.sig_v = sig_v;
    e.pass = pass; e.pass_v = pass_v; e.detail = detail;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue one expectation per cycle, LOAD through DONE
  task automatic push_run(input logic [PIW-1:0] seed, input int n, input logic [POW-1:0] golden,
                          input logic detail, output logic [POW-1:0] fsig);
    logic [PIW-1:0] g;
    logic [POW-1:0] m;
    g = (seed == '0) ? PIW'(1) : seed;
    m = '0;
    sb.push_back(mk('0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, detail));
    for (int i = 0; i < n; i++) begin
      sb.push_back(mk(g, 1'b1, 1'b0, m, 1'b1, 1'b0, 1'b1, detail));
      m = misr_step(m, po_fn(g, po_mode, po_const));
      g = lfsr_step(g);
    end
    for (int i = 0; i < FC; i++) begin
      sb.push_back(mk('0, 1'b1, 1'b0, m, 1'b1, 1'b0, 1'b1, detail));
      m = misr_step(m, po_fn('0, po_mode, po_const));
    end
    sb.push_back(mk('0, 1'b0, 1'b1, m, 1'b1, (m == golden), 1'b1, 1'b1));
    fsig = m;
  endtask

  // Pop and compare one entry per cycle; the cycle count itself bounds the wait
  task automatic drain(input logic drop_start);
    exp_t e;
    int   k;
    k = 0;
    while (sb.size() > 0) begin
      @(negedge ck);
      e = sb.pop_front();
      k++;
      if (k == 1 && drop_start) bus.start = 1'b0;
      if (e.detail) begin
        check($sformatf("pi[c%0d]", k), 64'(bus.pi), 64'(e.pi));
        check($sformatf("busy[c%0d]", k), 64'(bus.busy), 64'(e.busy));
        check($sformatf("done[c%0d]", k), 64'(bus.done), 64'(e.done));
        if (e.sig_v) check($sformatf("sig[c%0d]", k), 64'(bus.signature), 64'(e.sig));
        if (e.pass_v) check($sformatf("pass[c%0d]", k), 64'(bus.pass), 64'(e.pass));
      end
    end
  endtask

  task automatic run(input logic [PIW-1:0] seed, input int n, input logic [POW-1:0] golden,
                     input logic detail, input logic hold, output logic [POW-1:0] fsig);
    @(negedge ck);
    bus.seed         = seed;
    bus.num_patterns = CW'(n);
    bus.golden       = golden;
    bus.start        = 1'b1;
    push_run(seed, n, golden, detail, fsig);
    drain(!hold);
  endtask

  initial begin
    logic [POW-1:0] fs;
    int             dcnt;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_patterns = '0;
    bus.seed = '0;
    bus.golden = '0;
    po_mode = 1'b0;
    po_const = '0;
    repeat (3) @(negedge ck);
    check("rst_pi", 64'(bus.pi), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_pass", 64'(bus.pass), 64'h0);
    check("rst_sig", 64'(bus.signature), 64'h0);
    rst = 1'b0;

    // Zero patterns: DONE in cycle 6, empty signature matches zero golden
    run('0, 0, '0, 1'b1, 1'b0, fs);
    check("np0_pass", 64'(bus.pass), 64'h1);
    check("np0_sig", 64'(bus.signature), 64'h0);

    // Walking one from seed 1, then seed 0 falls back to 1
    run(35'h1, 3, '0, 1'b1, 1'b0, fs);
    run(35'h0, 1, '0, 1'b1, 1'b0, fs);

    // Constant response 1: signature walks 1,3,7,F,1F
    po_const = 23'h000001;
    run(35'h1, 1, 23'h000002, 1'b1, 1'b0, fs);
    check("c1_sig", 64'(bus.signature), 64'h1F);
    check("c1_pass_bad", 64'(bus.pass), 64'h0);
    run(35'h1, 1, 23'h00001F, 1'b1, 1'b0, fs);
    check("c1_pass_ok", 64'(bus.pass), 64'h1);
    @(negedge ck);
    check("pass_hold_idle", 64'(bus.pass), 64'h1);
    check("idle_sig_hold", 64'(bus.signature), 64'h1F);

    // Pattern-dependent response with both feedback taps exercised
    po_mode = 1'b1;
    run(35'h5_0000_0001, 40, 23'h123456, 1'b1, 1'b0, fs);
    run(35'h5_0000_0001, 40, fs, 1'b1, 1'b0, fs);
    check("mix_pass", 64'(bus.pass), 64'h1);

    // Reset during RUN cycle 3 of 10
    po_mode = 1'b0;
    po_const = 23'h000003;
    @(negedge ck);
    bus.seed = 35'h7;
    bus.num_patterns = CW'(10);
    bus.golden = '0;
    bus.start = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    repeat (3) @(negedge ck);
    check("mid_pi", 64'(bus.pi), 64'd28);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'h0);
    check("mid_rst_sig", 64'(bus.signature), 64'h0);
    check("mid_rst_pi", 64'(bus.pi), 64'h0);
    check("mid_rst_pass", 64'(bus.pass), 64'h0);
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge ck);
      if (bus.done || bus.busy) dcnt++;
    end
    check("mid_rst_quiet", 64'(dcnt), 64'h0);
    run(35'h7, 5, '0, 1'b1, 1'b0, fs);

    // Reset beats START in the same cycle
    @(negedge ck);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge ck);
    check("rst_prio_busy", 64'(bus.busy), 64'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge ck);
    check("rst_prio_idle", 64'(bus.busy), 64'h0);

    // START held: one run, one DONE; restart only via IDLE
    run(35'h3, 2, '0, 1'b1, 1'b1, fs);
    @(negedge ck);
    check("hold_idle_busy", 64'(bus.busy), 64'h0);
    check("hold_idle_done", 64'(bus.done), 64'h0);
    @(negedge ck);
    check("hold_reload_busy", 64'(bus.busy), 64'h1);
    bus.start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (bus.done) dcnt++;
    end
    check("hold_second_done", 64'(dcnt), 64'h1);

    // Full-scale count: exactly 2^16-1 RUN cycles, no wrap
    po_const = '0;
    run(35'h1, 65535, '0, 1'b0, 1'b0, fs);
    check("max_pass", 64'(bus.pass), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameter PI_WIDTH, default 35: width of the pattern bus driven into the circuit under test (CUT).
REQ-002 Parameter PO_WIDTH, default 23: width of the CUT response bus.
REQ-003 Parameter CNT_WIDTH, default 16: width of the pattern counter.
REQ-004 Parameter FLUSH_CYCLES, default 4: number of zero-pattern cycles applied after the last pattern.
REQ-005 CK  in  1  single system clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 START  in  1  begin a test run; sampled only in IDLE.
REQ-008 NUM_PATTERNS  in  CNT_WIDTH  number of pseudo-random patterns to apply.
REQ-009 SEED  in  PI_WIDTH  initial pattern-generator state; sampled in LOAD.
REQ-010 GOLDEN  in  PO_WIDTH  expected final signature; sampled at FLUSH->DONE.
REQ-011 PO  in  PO_WIDTH  CUT response, combinationally valid in the same cycle as PI.
REQ-012 PI  out  PI_WIDTH  pattern to the CUT.
REQ-013 BUSY  out  1  high in LOAD, RUN and FLUSH.
REQ-014 DONE  out  1  one-cycle pulse when the run completes.
REQ-015 PASS  out  1  final signature equals GOLDEN; held until the next START is accepted.
REQ-016 SIGNATURE  out  PO_WIDTH  current compactor state.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN, FLUSH and DONE.
REQ-018 Transitions: IDLE->LOAD on START=1; LOAD->RUN if NUM_PATTERNS!=0, else LOAD->FLUSH; RUN->FLUSH after NUM_PATTERNS RUN cycles; FLUSH->DONE after FLUSH_CYCLES cycles; DONE->IDLE unconditionally.
REQ-019 LOAD: generator <= SEED, or 1 if SEED==0 (lock-up avoidance); MISR <= 0; counter <= 0; PASS <= 0; PI=0.
REQ-020 Generator: Fibonacci LFSR, next = {g[PI_WIDTH-2:0], g[34]^g[32]} (x^35+x^33+1); advances only in RUN.
REQ-021 RUN: PI = current generator state; counter increments by 1 per cycle; NUM_PATTERNS is sampled at LOAD and held for the run.
REQ-022 MISR update in RUN and FLUSH: next = {m[21:0], m[22]^m[17]} XOR PO (x^23+x^18+1); MISR holds in all other states.
REQ-023 FLUSH: PI=0; a separate flush counter runs 0..FLUSH_CYCLES-1.
REQ-024 On the FLUSH->DONE edge: PASS <= (next MISR value == GOLDEN).
REQ-025 DONE=1 only in the DONE state; BUSY=0 in IDLE and DONE; PI=0 outside RUN.
REQ-026 Latency: with START accepted at edge 0, DONE is high in cycle NUM_PATTERNS+FLUSH_CYCLES+2.
REQ-027 START outside IDLE SHALL be ignored, with no effect on the counter, MISR or outputs.
REQ-028 The pattern counter SHALL NOT wrap: NUM_PATTERNS = 2^CNT_WIDTH-1 gives exactly that many RUN cycles.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE and clear the generator, MISR, both counters and PASS, in any state including mid-RUN.
REQ-030 Reset values: PI=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0.
REQ-031 RST SHALL have priority over START in the same cycle.

Structure
REQ-032 Shared package bist_pkg SHALL hold: the state enum; the LFSR and MISR tap constants; default widths; FLUSH_CYCLES default.
REQ-033 The MISR SHALL be one sub-module, bist_misr (parameterised width and taps, with enable and clear); the generator and FSM stay in bist_sequencer.

Verification
REQ-034 PO tied 0, NUM_PATTERNS=0, GOLDEN=0, START pulse -> DONE high in cycle 6, PASS=1, SIGNATURE=0.
REQ-035 SEED=35'h1, NUM_PATTERNS=3 -> PI = 35'h1, 35'h2, 35'h4 in RUN cycles 2-4, then 0 for 4 FLUSH cycles; DONE in cycle 9.
REQ-036 SEED=0, NUM_PATTERNS=1 -> PI=35'h1 in the single RUN cycle.
REQ-037 PO=23'h000001 constant, NUM_PATTERNS=1, GOLDEN=23'h000002 -> MISR values 1, 3, 7, 23'h0F, 23'h1F -> PASS=0; a rerun with GOLDEN=23'h00001F -> PASS=1.
REQ-038 RST in RUN cycle 3 of 10 -> next cycle IDLE, BUSY=0, SIGNATURE=0, no DONE pulse; a new START then completes normally.
REQ-039 START held high for the whole run -> exactly one run and one DONE pulse; a second run starts only from IDLE (after DONE).
